// File: rtl/imem_pkg.sv
// ============================================================================
// Module  : imem_pkg
// Brief   : Shared widths, opcode constants and loader state encoding.
//           IMEM_LOADER_CHECKSUM_EN adds the checksum (CHK) state.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 4;

    localparam logic [3:0] c_op_nop = 4'h0;
    localparam logic [3:0] c_op_ldi = 4'h1;
    localparam logic [3:0] c_op_add = 4'h2;
    localparam logic [3:0] c_op_sub = 4'h3;
    localparam logic [3:0] c_op_jmp = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK   = 3'd4,
`endif
        DONE  = 3'd5
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module  : imem_loader_if
// Brief   : Byte-stream input and instruction-memory write port of the loader.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 4
);
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;

    // master = loader side, slave = byte source / memory side
    modport master (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module  : imem_loader
// Brief   : Assembles little-endian byte pairs into instructions and writes
//           them to instruction memory while holding the CPU.
//           Optional: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int INSTR_W = imem_pkg::INSTR_W,
    parameter int ADDR_W  = imem_pkg::ADDR_W
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          start,
    input  wire logic [ADDR_W:0] load_len,
    imem_loader_if.master      bus,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);
    import imem_pkg::*;

    localparam logic [ADDR_W:0] c_full = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_one  = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t      r_state;
    loader_state_t      w_next;
    logic [ADDR_W:0]    r_len;
    logic [ADDR_W-1:0]  r_addr;
    logic [INSTR_W-1:0] r_data;
    logic [ADDR_W:0]    w_len_eff;
    logic               w_accept;
    logic               w_last;
    logic               w_byte_ready;
    logic               w_wr_en;

    // Zero and oversize lengths both mean a full memory, so wr_addr never wraps.
    assign w_len_eff = ((load_len == '0) || (load_len > c_full)) ? c_full : load_len;
    assign w_accept  = bus.byte_valid && w_byte_ready;
    assign w_last    = (({1'b0, r_addr} + c_one) == r_len);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_byte_ready = 1'b0;
        w_wr_en      = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                cpu_hold = 1'b0;
                if (start) w_next = LO;
            end
            LO: begin
                w_byte_ready = 1'b1;
                if (w_accept) w_next = HI;
            end
            HI: begin
                w_byte_ready = 1'b1;
                if (w_accept) w_next = WRITE;
            end
            WRITE: begin
                w_wr_en = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_next  = w_last ? CHK : LO;
`else
                w_next  = w_last ? DONE : LO;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                w_byte_ready = 1'b1;
                if (w_accept) w_next = DONE;
            end
`endif
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len  <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_len  <= w_len_eff;
                    r_addr <= '0;
                end
                LO:    if (w_accept) r_data[7:0]  <= bus.byte_data;
                HI:    if (w_accept) r_data[15:8] <= bus.byte_data;
                WRITE: if (!w_last)  r_addr       <= r_addr + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum <= '0;
            r_err  <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_csum <= '0;
            r_err  <= 1'b0;
        end else if (w_accept && ((r_state == LO) || (r_state == HI))) begin
            r_csum <= r_csum ^ bus.byte_data;
        end else if (w_accept && (r_state == CHK)) begin
            r_err  <= r_err | (bus.byte_data != r_csum);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign bus.byte_ready = w_byte_ready;
    assign bus.wr_en      = w_wr_en;
    assign bus.wr_addr    = r_addr;
    assign bus.wr_data    = r_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module  : tb_imem_loader
// Brief   : Directed self-checking bench for imem_loader.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int IW = 16;
    localparam int AW = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    logic [AW+IW-1:0] wq[$];
    logic [7:0]       csum;
    logic [7:0]       lo_b;
    logic [7:0]       hi_b;

    imem_loader_if #(.INSTR_W(IW), .ADDR_W(AW)) bus ();

    imem_loader #(.INSTR_W(IW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .load_len (load_len),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Record every memory write as {addr, data}
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wq.push_back({bus.wr_addr, bus.wr_data});
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int n = 0; n < 20; n++) begin
            if (bus.byte_ready === 1'b1) begin
                tick();
                bus.byte_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.byte_valid = 1'b0;
        checks++;
        errors++;
        $error("FAIL send_byte_timeout: observed=byte_ready low expected=byte_ready within 20 cycles");
    endtask

    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi,
                             input logic [AW-1:0] exp_addr);
        send_byte(lo);
        send_byte(hi);
        check("write_en",    32'(bus.wr_en),      32'h1);
        check("write_addr",  32'(bus.wr_addr),    32'(exp_addr));
        check("write_data",  32'(bus.wr_data),    {16'h0, hi, lo});
        check("write_noready", 32'(bus.byte_ready), 32'h0);
        tick();
    endtask

    task automatic begin_load(input logic [AW:0] len);
        load_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic finish_load(input logic [7:0] cs, input logic exp_err);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("chk_ready", 32'(bus.byte_ready), 32'h1);
        send_byte(cs);
`else
        check("no_chk_ready", 32'(bus.byte_ready), 32'(cs & 8'h0));
`endif
        check("done_pulse",  32'(done),     32'h1);
        check("done_err",    32'(err),      32'(exp_err));
        check("done_wr_en",  32'(bus.wr_en), 32'h0);
        tick();
        check("done_clear",  32'(done),     32'h0);
        check("hold_release", 32'(cpu_hold), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},    32'(bus.wr_en),      32'h0);
        check({tag, "_wr_addr"},  32'(bus.wr_addr),    32'h0);
        check({tag, "_wr_data"},  32'(bus.wr_data),    32'h0);
        check({tag, "_ready"},    32'(bus.byte_ready), 32'h0);
        check({tag, "_hold"},     32'(cpu_hold),       32'h0);
        check({tag, "_done"},     32'(done),           32'h0);
        check({tag, "_err"},      32'(err),            32'h0);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("idle_hold", 32'(cpu_hold), 32'h0);
        check("idle_ready", 32'(bus.byte_ready), 32'h0);

        // Two words back-to-back
        begin_load(5'd2);
        check("t1_hold",  32'(cpu_hold),       32'h1);
        check("t1_ready", 32'(bus.byte_ready), 32'h1);
        check("t1_addr",  32'(bus.wr_addr),    32'h0);
        wq.delete();
        send_word(8'h05, 8'h12, 4'd0);
        send_word(8'h02, 8'h14, 4'd1);
        finish_load(8'h01, 1'b0);
        check("t1_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check("t1_w0", 32'(wq[0]), 32'h0_1205);
            check("t1_w1", 32'(wq[1]), 32'h1_1402);
        end

        // Source stalls between LO and HI bytes
        begin_load(5'd1);
        wq.delete();
        send_byte(8'hAA);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_stall_wr_en", 32'(bus.wr_en),   32'h0);
            check("t2_stall_data",  32'(bus.wr_data), 32'h14AA);
        end
        send_byte(8'h55);
        check("t2_wr_en",   32'(bus.wr_en),   32'h1);
        check("t2_wr_data", 32'(bus.wr_data), 32'h55AA);
        tick();
        finish_load(8'hFF, 1'b0);
        check("t2_nwrites", 32'(wq.size()), 32'd1);

        // Full 16-word load, with an ignored start in the middle
        begin_load(5'd0);
        wq.delete();
        csum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            lo_b = 8'(i);
            hi_b = 8'hA0 | 8'(i);
            if (i == 5) begin
                start    = 1'b1;
                load_len = 5'd3;
                tick();
                start    = 1'b0;
                check("t3_start_ignored_addr", 32'(bus.wr_addr), 32'd5);
                check("t3_start_ignored_hold", 32'(cpu_hold),    32'h1);
            end
            send_word(lo_b, hi_b, 4'(i));
            csum = csum ^ lo_b ^ hi_b;
        end
        finish_load(csum, 1'b0);
        tick();
        tick();
        check("t3_nwrites", 32'(wq.size()), 32'd16);
        if (wq.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("t3_seq", 32'(wq[i]), {12'h0, 4'(i), 8'hA0 | 8'(i), 8'(i)});
            end
        end

        // Reset after the LO byte of word 3
        begin_load(5'd5);
        wq.delete();
        send_word(8'h10, 8'h20, 4'd0);
        send_word(8'h11, 8'h21, 4'd1);
        send_word(8'h12, 8'h22, 4'd2);
        send_byte(8'h33);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("t4_no_write", 32'(bus.wr_en), 32'h0);
        check("t4_idle",     32'(cpu_hold),  32'h0);
        check("t4_nwrites",  32'(wq.size()), 32'd3);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good then bad
        begin_load(5'd1);
        send_word(8'h05, 8'h12, 4'd0);
        finish_load(8'h17, 1'b0);
        begin_load(5'd1);
        send_word(8'h05, 8'h12, 4'd0);
        finish_load(8'h00, 1'b1);
        tick();
        check("t5_err_sticky", 32'(err), 32'h1);
        begin_load(5'd1);
        check("t5_err_cleared", 32'(err), 32'h0);
`else
        check("t5_err_const", 32'(err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
